// File: rtl/wave_dds_core.sv
// wave_dds_core: phase-accumulator control and output stage of the
// four-waveform generator.
//
// Key pulses step pending frequency, waveform and amplitude settings. The
// pending values move into the active set only on a phase wrap, so a period
// is never altered part-way through. The top ADDR_W phase bits address four
// external registered ROMs. The ROM sample selected by the active waveform
// is scaled by an arithmetic right shift around mid-scale.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   freq_step         pulse: pending frequency index +1 (mod 16)
//   wave_step         pulse: pending waveform +1 (0 sin,1 square,2 saw,3 tri)
//   amp_step          pulse: pending amplitude shift +1 (mod 4)
//   rom_rden          read enable to all ROMs (registered)
//   rom_addr          shared ROM address (top bits of the phase register)
//   sin_q .. tri_q    ROM data, one-cycle read latency
//   dout              scaled sample, offset binary, 0x80 = mid-scale
//   sync              marks the first dout sample of each period
module wave_dds_core #(
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BASE_INC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freq_step,
  input  logic              wave_step,
  input  logic              amp_step,
  output logic              rom_rden,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        sin_q,
  input  logic [7:0]        square_q,
  input  logic [7:0]        saw_q,
  input  logic [7:0]        tri_q,
  output logic [7:0]        dout,
  output logic              sync
);

  localparam int unsigned FREQ_W = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 8;

  logic [PHASE_W-1:0] phase;
  logic [FREQ_W-1:0]  freq_pend, freq_act;
  logic [SEL_W-1:0]   wave_pend, wave_act, wave_d;
  logic [SEL_W-1:0]   amp_pend, amp_act, amp_d;
  logic               wrap_d1, wrap_d2;

  logic [PHASE_W-1:0]      tw_c;
  logic [PHASE_W:0]        sum_c;
  logic                    wrap_c;
  logic [DATA_W-1:0]       q_c;
  logic signed [DATA_W-1:0] s_c;
  logic signed [DATA_W-1:0] s_shift_c;
  logic [DATA_W-1:0]       dout_next_c;

  // Tuning word. Multiplying at PHASE_W width gives the same low bits as a
  // full-width product truncated afterwards.
  assign tw_c   = PHASE_W'(BASE_INC) * (PHASE_W'(freq_act) + PHASE_W'(1));
  assign sum_c  = {1'b0, phase} + {1'b0, tw_c};
  assign wrap_c = rom_rden & sum_c[PHASE_W];

  assign rom_addr = phase[PHASE_W-1 -: ADDR_W];

  // Read enable rises on the first edge out of reset and then stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_rden <= 1'b0;
    else        rom_rden <= 1'b1;
  end

  // Phase accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        phase <= '0;
    else if (rom_rden) phase <= sum_c[PHASE_W-1:0];
  end

  // Pending settings, stepped by the key pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_pend <= '0;
      wave_pend <= '0;
      amp_pend  <= '0;
    end else begin
      if (freq_step) freq_pend <= freq_pend + FREQ_W'(1);
      if (wave_step) wave_pend <= wave_pend + SEL_W'(1);
      if (amp_step)  amp_pend  <= amp_pend + SEL_W'(1);
    end
  end

  // Active settings take the pre-edge pending values on the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_act <= '0;
      wave_act <= '0;
      amp_act  <= '0;
    end else if (wrap_c) begin
      freq_act <= freq_pend;
      wave_act <= wave_pend;
      amp_act  <= amp_pend;
    end
  end

  // Align waveform/amplitude with ROM data and the wrap marker with dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_d  <= '0;
      amp_d   <= '0;
      wrap_d1 <= 1'b0;
      wrap_d2 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      wave_d  <= wave_act;
      amp_d   <= amp_act;
      wrap_d1 <= wrap_c;
      wrap_d2 <= wrap_d1;
      sync    <= wrap_d2;
    end
  end

  // Waveform select and scaling around mid-scale.
  always_comb begin
    q_c = sin_q;
    unique case (wave_d)
      2'd0:    q_c = sin_q;
      2'd1:    q_c = square_q;
      2'd2:    q_c = saw_q;
      default: q_c = tri_q;
    endcase
    s_c         = signed'(q_c ^ 8'h80);
    s_shift_c   = s_c >>> amp_d;
    dout_next_c = DATA_W'(s_shift_c) ^ 8'h80;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 8'h80;
    else        dout <= dout_next_c;
  end

endmodule

// File: doc/wave_dds_core.md
# wave_dds_core

Phase-accumulator control and output stage for the four-waveform generator. Turns debounced key pulses into frequency, waveform and amplitude settings, drives the shared 8-bit address and read enable of the sine, square, sawtooth and triangle ROMs, and selects and scales the returned ROM sample onto the 8-bit DAC output. All setting changes take effect only at a phase wrap, so the output never glitches mid-period.

## Interface
- PHASE_W, 24, phase accumulator width (≥ ADDR_W+1)
- ADDR_W, 8, ROM address width; address = top ADDR_W bits of phase
- BASE_INC, 1024, tuning-word unit; tuning word = BASE_INC × (freq_idx+1), truncated to PHASE_W
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- freq_step  in  1  one-cycle pulse (debounced key1): pending freq_idx +1, 15→0 wrap
- wave_step  in  1  one-cycle pulse (debounced key2): pending wave_sel +1, 3→0 wrap (0 sin, 1 square, 2 sawtooth, 3 triangle)
- amp_step  in  1  one-cycle pulse (debounced key3): pending amp_shift +1, 3→0 wrap
- rom_rden  out  1  read enable to all four ROMs
- rom_addr  out  ADDR_W  shared ROM address
- sin_q, square_q, saw_q, tri_q  in  8 each  ROM data, registered ROMs, 1-cycle read latency
- dout  out  8  scaled sample, offset binary, 0x80 = mid-scale
- sync  out  1  one-cycle pulse marking the first dout sample of each period

## Operation
- Reset state: phase=0, all pending and active settings 0, rom_rden=0, rom_addr=0, dout=0x80, sync=0.
- rom_rden is a register. It goes to 1 on the first clk edge after rst_n deasserts and stays 1.
- Accumulator:
  - Advances only while rom_rden=1: phase <= phase + tw_active, modulo 2^PHASE_W.
  - rom_addr = phase[PHASE_W-1 -: ADDR_W], taken directly from the phase register.
- Wrap: `wrap` is asserted in the cycle where the carry out of the accumulator add is 1.
- Pending registers:
  - Each pending register updates on the clk edge following its step pulse.
  - Pulses on different inputs in the same cycle are all applied.
- Active registers load from the pending registers on the same edge that wraps the phase.
  - Each active register loads its pending value as it was before that edge.
  - A step pulse coincident with a wrap is therefore applied at the next wrap.
- tw_active is computed from active freq_idx:
  - BASE_INC × (freq_idx+1), with a full-width product.
  - The result is truncated to PHASE_W bits.
- Output path:
  - Active wave_sel and amp_shift are delayed 1 cycle so they align with the ROM data.
  - The mux picks q from that delayed wave_sel.
  - Scaling: s = q ^ 0x80, treated as signed 8-bit; s' = s >>> amp_shift (arithmetic shift); dout <= s' ^ 0x80.
- sync: the wrap flag is delayed 2 cycles. sync is 1 in the cycle where dout carries the sample read from the first post-wrap address.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous). Pending step counts are lost.

## Timing
- Cycle t: rom_addr = A(t). The ROM samples it at edge t+1, and q is valid during cycle t+1. dout(A(t)) is registered at edge t+2.
- Address-to-dout latency: 2 cycles. The wave_sel and amp_shift applied to a sample are the active values in the cycle its address was presented.
- After reset release:
  - Edge 1: rom_rden=1 and phase is still 0.
  - Edge 2: first increment.
  - rom_addr=0 is held for at least 2 cycles.
- Setting change latency: step pulse → pending at +1 edge → active at the next wrap edge → visible on dout 2 cycles later, aligned with sync.
- No backpressure and no handshake. Step pulses are assumed to be ≥1 cycle apart per input, and each pulse counts once.

## Test plan
- Reset: hold rst_n=0 with random inputs → rom_rden=0, rom_addr=0, dout=0x80, sync=0. Release → rom_rden=1 after 1 edge.
- Step rate (PHASE_W=16, ADDR_W=8, BASE_INC=256): rom_addr advances by +1 per cycle, 0..255. sync occurs every 256 cycles, 2 cycles after the 255→0 address transition.
- Deferred frequency change: pulse freq_step at addr=100 → step stays 1 through 255, becomes 2 from address 0, then the next wrap comes after 128 cycles. Sixteen pulses return the step to 1.
- Waveform switch: ROM models return distinct constants (sin 0x11, square 0x22, saw 0x33, tri 0x44). Pulse wave_step mid-period → dout changes 0x11→0x22 exactly in the sync cycle. Four pulses return to 0x11.
- Amplitude: amp_shift=1 maps q 0xFF→dout 0xBF, 0x00→0x40, 0x80→0x80. amp_shift=3 maps 0xFF→0x8F and 0x00→0x70.
- Coincident pulse and mid-run reset: wave_step in the wrap cycle → change deferred one full period. rst_n pulsed low mid-period → dout=0x80 at once, settings revert to sine/idx 0/shift 0, and the restart sequence matches the Reset scenario.
